// File: rtl/nn_pkg.sv
// Shared definitions for the neuron engine.
//
// Contents:
//   state_e        : evaluation FSM states (IDLE, RUN, ACT, DONE)
//   ACT_LEAK_SHIFT : right-shift applied to negative values by the leaky ReLU
//   clog2          : ceiling log2, usable in constant expressions
//   numBeats       : accumulation beats needed to cover n elements with a given lane count
//   accWidth       : accumulator width that cannot overflow for n products plus bias
//   beatWidth      : width of the beat counter for k beats (never less than 1)
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ACT  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int ACT_LEAK_SHIFT = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int numBeats(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    // n products of 2*dw bits plus the bias fit in n+1 terms; one extra sign bit.
    function automatic int accWidth(input int n, input int dw);
        return 2 * dw + clog2(n + 1) + 1;
    endfunction

    function automatic int beatWidth(input int k);
        return (clog2(k + 1) < 1) ? 1 : clog2(k + 1);
    endfunction

endpackage

// File: rtl/mac_lanes.sv
// Combinational multiply lanes for the neuron engine.
//
// Sums the signed products of LANES input/weight pairs. Lane 0 sits in the
// MSBs of each packed vector. A lane whose enable bit is low contributes 0,
// which is how the engine masks the tail lanes past element N-1.
//
// Ports:
//   inLanes_i     : LANES packed signed inputs, DW bits each
//   weightLanes_i : LANES packed signed weights, same packing
//   laneEn_i      : per-lane enable mask, bit l enables lane l
//   sum_o         : ACC_W-bit signed sum of the enabled products
module mac_lanes #(
    parameter int LANES = 2,
    parameter int DW    = 8,
    parameter int ACC_W = 21
) (
    input  logic [LANES*DW-1:0] inLanes_i,
    input  logic [LANES*DW-1:0] weightLanes_i,
    input  logic [LANES-1:0]    laneEn_i,
    output logic [ACC_W-1:0]    sum_o
);

    logic signed [2*DW-1:0] prodRaw [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign prodRaw[l] = $signed(inLanes_i[(LANES-1-l)*DW +: DW])
                          * $signed(weightLanes_i[(LANES-1-l)*DW +: DW]);
    end

    // Sign-extend each enabled product to the accumulator width and add.
    always_comb begin
        sum_o = '0;
        for (int l = 0; l < LANES; l++) begin
            if (laneEn_i[l]) begin
                sum_o = sum_o + {{(ACC_W-2*DW){prodRaw[l][2*DW-1]}}, prodRaw[l]};
            end
        end
    end

endmodule

// File: rtl/neuron_engine.sv
// Neuron engine: N-input multiply-accumulate with bias, saturation and
// ReLU activation, result delivered over a valid/ready handshake.
//
// Operands are latched on the accepted start, then accumulated LANES
// products per beat over K = ceil(N/LANES) beats. One further cycle
// saturates to OUT_W bits and applies the activation.
//
// Configuration macro:
//   NEURON_LEAKY_RELU_EN : when defined, negative values are shifted right
//                          arithmetically by ACT_LEAK_SHIFT instead of
//                          being forced to zero.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : begin an evaluation (only honoured when idle)
//   in_vec    : N packed signed inputs, element 0 in the MSBs
//   w_vec     : N packed signed weights, same packing
//   bias      : signed bias
//   busy      : high from start acceptance until the result is taken
//   out_valid : result is available
//   out_ready : consumer takes the result
//   result    : activated, saturated output
module neuron_engine
    import nn_pkg::*;
#(
    parameter int N     = 8,
    parameter int DW    = 8,
    parameter int LANES = 2,
    parameter int OUT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N*DW-1:0]   in_vec,
    input  logic [N*DW-1:0]   w_vec,
    input  logic [DW-1:0]     bias,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  result
);

    localparam int K      = numBeats(N, LANES);
    localparam int ACC_W  = accWidth(N, DW);
    localparam int BEAT_W = beatWidth(K);
    localparam int SLICE  = LANES * DW;
    localparam int TOT_W  = K * SLICE;
    localparam int PAD_W  = TOT_W - N * DW;

    state_e              state_q;
    logic [N*DW-1:0]     in_q;
    logic [N*DW-1:0]     w_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [BEAT_W-1:0]   beat_q;
    logic                busy_q;
    logic                valid_q;
    logic [OUT_W-1:0]    result_q;

    logic [TOT_W-1:0]    inPad;
    logic [TOT_W-1:0]    wPad;
    logic [TOT_W-1:0]    inShift;
    logic [TOT_W-1:0]    wShift;
    logic [SLICE-1:0]    inBeat;
    logic [SLICE-1:0]    wBeat;
    logic [LANES-1:0]    laneEn;
    logic [ACC_W-1:0]    macSum;
    logic [ACC_W-1:0]    biasExt;
    logic [OUT_W-1:0]    satVal;
    logic [OUT_W-1:0]    actVal;

    // Pad the operand vectors up to a whole number of beats so every beat
    // can take a fixed-width slice; the padding lanes are also masked off.
    if (PAD_W > 0) begin : g_pad
        assign inPad = {in_q, {PAD_W{1'b0}}};
        assign wPad  = {w_q,  {PAD_W{1'b0}}};
    end else begin : g_nopad
        assign inPad = in_q;
        assign wPad  = w_q;
    end

    // Shifting left by one slice per beat brings the current beat's
    // elements to the top of the vector.
    always_comb begin
        inShift = inPad << (int'(beat_q) * SLICE);
        wShift  = wPad  << (int'(beat_q) * SLICE);
        inBeat  = inShift[TOT_W-1 -: SLICE];
        wBeat   = wShift[TOT_W-1 -: SLICE];
    end

    always_comb begin
        laneEn = '0;
        for (int l = 0; l < LANES; l++) begin
            laneEn[l] = (int'(beat_q) * LANES + l) < N;
        end
    end

    mac_lanes #(
        .LANES (LANES),
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .inLanes_i     (inBeat),
        .weightLanes_i (wBeat),
        .laneEn_i      (laneEn),
        .sum_o         (macSum)
    );

    assign biasExt = {{(ACC_W-DW){bias[DW-1]}}, bias};
    assign acc_d   = acc_q + macSum;

    // The value fits in OUT_W bits when every bit from the OUT_W sign bit
    // upward agrees; otherwise clamp toward the accumulator's sign.
    if (ACC_W >= OUT_W) begin : g_sat
        logic [ACC_W-OUT_W:0] upper;
        assign upper = acc_q[ACC_W-1:OUT_W-1];
        always_comb begin
            if ((&upper) || !(|upper)) begin
                satVal = acc_q[OUT_W-1:0];
            end else if (acc_q[ACC_W-1]) begin
                satVal = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                satVal = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end else begin : g_nosat
        assign satVal = {{(OUT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    end

    always_comb begin
        actVal = satVal;
        if (satVal[OUT_W-1]) begin
`ifdef NEURON_LEAKY_RELU_EN
            actVal = $signed(satVal) >>> ACT_LEAK_SHIFT;
`else
            actVal = '0;
`endif
        end
    end

    // Evaluation FSM. Operands are captured only on an accepted start, so
    // later changes on the input buses or extra start pulses cannot disturb
    // an evaluation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            in_q     <= '0;
            w_q      <= '0;
            acc_q    <= '0;
            beat_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        in_q    <= in_vec;
                        w_q     <= w_vec;
                        acc_q   <= biasExt;
                        beat_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == BEAT_W'(K - 1)) begin
                        state_q <= ACT;
                    end
                end
                ACT: begin
                    result_q <= actVal;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_neuron_engine.sv
// Self-checking bench for neuron_engine: a default-parameter instance
// (N=8, LANES=2) and a second instance with N=5 exercising the masked tail
// lane. Expected results come from constants and a small behavioural model,
// are queued when a start is driven and popped when out_valid appears.
module tb_neuron_engine;

    localparam int N     = 8;
    localparam int DW    = 8;
    localparam int LANES = 2;
    localparam int OUT_W = 16;
    localparam int LAT_A = 5;
    localparam int LAT_B = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [N*DW-1:0]  in_vec;
    logic [N*DW-1:0]  w_vec;
    logic [DW-1:0]    bias;
    logic             out_ready;
    logic             busy;
    logic             out_valid;
    logic [OUT_W-1:0] result;

    logic             bStart;
    logic [5*DW-1:0]  bIn;
    logic [5*DW-1:0]  bW;
    logic [DW-1:0]    bBias;
    logic             bReady;
    logic             bBusy;
    logic             bValid;
    logic [OUT_W-1:0] bResult;

    int checks = 0;
    int fails  = 0;
    logic [OUT_W-1:0] expQ [$];

    typedef struct {
        logic [63:0] iv;
        logic [63:0] wv;
        logic [7:0]  b;
        logic [15:0] expv;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    neuron_engine #(.N(N), .DW(DW), .LANES(LANES), .OUT_W(OUT_W)) dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_vec    (in_vec),
        .w_vec     (w_vec),
        .bias      (bias),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    neuron_engine #(.N(5), .DW(DW), .LANES(2), .OUT_W(OUT_W)) dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (bStart),
        .in_vec    (bIn),
        .w_vec     (bW),
        .bias      (bBias),
        .busy      (bBusy),
        .out_valid (bValid),
        .out_ready (bReady),
        .result    (bResult)
    );

    // Stop a hung run with a visible failure.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [15:0] modelResult(input logic [63:0] iv, input logic [63:0] wv,
                                                input logic [7:0] b, input int n);
        int acc;
        int a;
        int w;
        int s;
        logic [7:0] ib;
        logic [7:0] wb;
        acc = int'($signed(b));
        for (int e = 0; e < n; e++) begin
            ib = iv[(n-1-e)*8 +: 8];
            wb = wv[(n-1-e)*8 +: 8];
            a = int'($signed(ib));
            w = int'($signed(wb));
            acc = acc + a * w;
        end
        s = acc;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (s < 0) begin
`ifdef NEURON_LEAKY_RELU_EN
            s = s >>> 3;
`else
            s = 0;
`endif
        end
        return s[15:0];
    endfunction

    // Waits (bounded) for out_valid, sampling 1 time unit after each edge,
    // and returns the number of edges seen since the start edge.
    task automatic waitValid(output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic popCheck(input string name);
        logic [15:0] e;
        if (expQ.size() == 0) begin
            checkOutput({name, " scoreboard"}, 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput({name, " result"}, 32'(result), 32'(e));
        end
    endtask

    // Drives one evaluation on the default instance and completes the
    // handshake; the input buses are scrambled right after the start edge.
    task automatic applyStimulus(input logic [63:0] iv, input logic [63:0] wv,
                                 input logic [7:0] b, input logic [15:0] expv, input string name);
        int edges;
        @(negedge clk);
        in_vec    = iv;
        w_vec     = wv;
        bias      = b;
        start     = 1'b1;
        out_ready = 1'b0;
        expQ.push_back(expv);
        @(posedge clk);
        #1;
        start  = 1'b0;
        in_vec = {$urandom, $urandom};
        w_vec  = {$urandom, $urandom};
        bias   = 8'($urandom);
        checkOutput({name, " busy at start"}, 32'(busy), 32'd1);
        waitValid(edges);
        checkOutput({name, " latency"}, 32'(edges), 32'(LAT_A));
        checkOutput({name, " busy before handshake"}, 32'(busy), 32'd1);
        popCheck(name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({name, " valid after handshake"}, 32'(out_valid), 32'd0);
        checkOutput({name, " busy after handshake"}, 32'(busy), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int edges;
        logic [15:0] held;

        rst_n = 1'b0; start = 1'b0; in_vec = '0; w_vec = '0; bias = '0; out_ready = 1'b0;
        bStart = 1'b0; bIn = '0; bW = '0; bBias = '0; bReady = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset valid", 32'(out_valid), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset B valid", 32'(bValid), 32'd0);
        rst_n = 1'b1;

        // Directed vectors first, then random ones scored by the model.
        tbl[0] = '{64'h0101010101010101, 64'h0202020202020202, 8'h03, 16'd19};
`ifdef NEURON_LEAKY_RELU_EN
        tbl[1] = '{64'h0101010101010101, 64'hFEFEFEFEFEFEFEFE, 8'h00, 16'hFFFE};
        tbl[3] = '{64'h8080808080808080, 64'h7F7F7F7F7F7F7F7F, 8'h00, 16'hF000};
`else
        tbl[1] = '{64'h0101010101010101, 64'hFEFEFEFEFEFEFEFE, 8'h00, 16'd0};
        tbl[3] = '{64'h8080808080808080, 64'h7F7F7F7F7F7F7F7F, 8'h00, 16'd0};
`endif
        tbl[2] = '{64'h7F7F7F7F7F7F7F7F, 64'h7F7F7F7F7F7F7F7F, 8'h7F, 16'd32767};
        for (int i = 4; i < 8; i++) begin
            tbl[i].iv = {$urandom, $urandom};
            tbl[i].wv = {$urandom, $urandom};
            tbl[i].b  = 8'($urandom_range(0, 255));
            tbl[i].expv = modelResult(tbl[i].iv, tbl[i].wv, tbl[i].b, 8);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].iv, tbl[i].wv, tbl[i].b, tbl[i].expv, $sformatf("vec%0d", i));
        end

        // N=5 instance: odd tail lane masked, three beats.
        @(negedge clk);
        bIn = 40'h0102030405; bW = 40'h0101010101; bBias = 8'hFF; bStart = 1'b1;
        @(posedge clk);
        #1;
        bStart = 1'b0; bIn = '1; bW = '1;
        edges = 0;
        while (!bValid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("tail latency", 32'(edges), 32'(LAT_B));
        checkOutput("tail result", 32'(bResult), 32'd14);
        @(negedge clk);
        bReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("tail busy after handshake", 32'(bBusy), 32'd0);
        @(negedge clk);
        bReady = 1'b0;

        // Back-pressure and ignored start pulses during RUN and DONE.
        @(negedge clk);
        in_vec = 64'h0101010101010101; w_vec = 64'h0202020202020202; bias = 8'h03; start = 1'b1;
        expQ.push_back(16'd19);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_vec = 64'h7F7F7F7F7F7F7F7F; w_vec = 64'h7F7F7F7F7F7F7F7F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitValid(edges);
        checkOutput("hold valid seen", 32'(out_valid), 32'd1);
        held = result;
        popCheck("hold");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("hold valid c%0d", c), 32'(out_valid), 32'd1);
            checkOutput($sformatf("hold result c%0d", c), 32'(result), 32'd19);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start in DONE valid", 32'(out_valid), 32'd1);
        checkOutput("start in DONE result", 32'(result), 32'(held));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("hold release busy", 32'(busy), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(64'h0101010101010101, 64'hFEFEFEFEFEFEFEFE, 8'h05,
                      modelResult(64'h0101010101010101, 64'hFEFEFEFEFEFEFEFE, 8'h05, 8), "after hold");

        // Ready already high: valid lasts one cycle; ready while idle does nothing.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready idle valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_vec = 64'h0101010101010101; w_vec = 64'h0202020202020202; bias = 8'h03; start = 1'b1;
        expQ.push_back(16'd19);
        @(posedge clk);
        #1;
        start = 1'b0;
        waitValid(edges);
        checkOutput("early ready latency", 32'(edges), 32'(LAT_A));
        popCheck("early ready");
        @(posedge clk);
        #1;
        checkOutput("early ready valid one cycle", 32'(out_valid), 32'd0);
        checkOutput("early ready busy", 32'(busy), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during RUN beat 2, then a clean evaluation.
        @(negedge clk);
        in_vec = 64'h7F7F7F7F7F7F7F7F; w_vec = 64'h7F7F7F7F7F7F7F7F; bias = 8'h7F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort valid", 32'(out_valid), 32'd0);
        checkOutput("abort result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(64'h0101010101010101, 64'h0202020202020202, 8'h03, 16'd19, "post abort");

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
